// File: rtl/sbm_digit_serial.sv
// sbm_digit_serial
// Digit-serial schoolbook multiplier. Computes the full unsigned product
// c = a * b by consuming one DIGIT-bit slice of b per clock. Each slice is
// multiplied by the whole of a, and the product is added into the
// accumulator at the slice's weight. b is zero-padded up to a whole number
// of digits. With EARLY_EXIT set, the run stops as soon as the remaining
// b digits are all zero.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset; aborts any operation in flight
//   start  request, accepted only while busy = 0
//   a      multiplicand (SIZEA bits), sampled on the accepting edge
//   b      multiplier (SIZEB bits), sampled on the accepting edge
//   busy   high from the cycle after acceptance until the done cycle
//   done   one-cycle pulse; c is valid in that cycle
//   c      product (SIZEA+SIZEB bits); holds until the next done
//
// States
//   IDLE | waiting for start, done pulse is cleared here
//   RUN  | one digit of b accumulated per edge
//   FIN  | accumulator copied to c, done raised, busy dropped

module sbm_digit_serial #(
    parameter int SIZEA      = 1024,
    parameter int SIZEB      = 1024,
    parameter int DIGIT      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SIZEA-1:0]       a,
    input  logic [SIZEB-1:0]       b,
    output logic                   busy,
    output logic                   done,
    output logic [SIZEA+SIZEB-1:0] c
);

    localparam int DIGITS = (SIZEB + DIGIT - 1) / DIGIT;
    localparam int BPAD   = DIGITS * DIGIT;
    localparam int ACCW   = SIZEA + SIZEB;
    localparam int PPW    = SIZEA + DIGIT;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int SW     = $clog2(BPAD + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SIZEA-1:0]  a_reg;
    logic [BPAD-1:0]   b_reg;
    logic [BPAD-1:0]   b_rest;
    logic [ACCW-1:0]   acc;
    logic [CW-1:0]     cnt;
    logic [PPW-1:0]    pp;
    logic [SW-1:0]     shamt;
    logic [ACCW-1:0]   pp_shifted;
    logic              last_digit;

    // Partial product of the current digit, placed at its weight.
    // A padded last digit only carries zero bits above SIZEB, so the
    // truncation to ACCW bits loses nothing.
    always_comb begin
        b_rest     = b_reg >> DIGIT;
        pp         = PPW'(a_reg) * PPW'(b_reg[DIGIT-1:0]);
        shamt      = SW'(cnt) * SW'(DIGIT);
        pp_shifted = ACCW'(pp) << shamt;
        last_digit = (cnt == CW'(DIGITS - 1)) || (EARLY_EXIT && (b_rest == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // A zero multiplier has nothing to accumulate.
                    if (EARLY_EXIT && (b == '0)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= BPAD'(b);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc + pp_shifted;
                    b_reg <= b_rest;
                    cnt   <= cnt + CW'(1);
                end
                FIN: begin
                    c    <= acc;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbm_digit_serial.sv
// Testbench for sbm_digit_serial. Four instances share clock and reset:
//   ne  : 32x32, 8-bit digits, always full run
//   ee  : 32x32, 8-bit digits, early exit
//   pad : 17x20, 8-bit digits (padded last digit), always full run
//   big : default 1024x1024, 16-bit digits, early exit
// The big instance is checked through a scoreboard queue: the expected
// product is pushed when an operation is driven and popped on done.

module tb_sbm_digit_serial;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    // small instances
    logic        start_ne, start_ee, start_pad;
    logic [31:0] a_ne, b_ne, a_ee, b_ee;
    logic [16:0] a_pad;
    logic [19:0] b_pad;
    logic        busy_ne, busy_ee, busy_pad;
    logic        done_ne, done_ee, done_pad;
    logic [63:0] c_ne, c_ee;
    logic [36:0] c_pad;

    // default-size instance
    logic          start_big;
    logic [1023:0] a_big, b_big;
    logic          busy_big, done_big;
    logic [2047:0] c_big;

    logic [2047:0] sb_q[$];
    logic [2047:0] prev_c = '0;
    bit            b2b = 1'b0;
    int            last_done = -1;

    sbm_digit_serial #(.SIZEA(32), .SIZEB(32), .DIGIT(8), .EARLY_EXIT(1'b0)) u_ne (
        .clk(clk), .rst(rst), .start(start_ne), .a(a_ne), .b(b_ne),
        .busy(busy_ne), .done(done_ne), .c(c_ne)
    );

    sbm_digit_serial #(.SIZEA(32), .SIZEB(32), .DIGIT(8), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst(rst), .start(start_ee), .a(a_ee), .b(b_ee),
        .busy(busy_ee), .done(done_ee), .c(c_ee)
    );

    sbm_digit_serial #(.SIZEA(17), .SIZEB(20), .DIGIT(8), .EARLY_EXIT(1'b0)) u_pad (
        .clk(clk), .rst(rst), .start(start_pad), .a(a_pad), .b(b_pad),
        .busy(busy_pad), .done(done_pad), .c(c_pad)
    );

    sbm_digit_serial #(.SIZEA(1024), .SIZEB(1024), .DIGIT(16), .EARLY_EXIT(1'b1)) u_big (
        .clk(clk), .rst(rst), .start(start_big), .a(a_big), .b(b_big),
        .busy(busy_big), .done(done_big), .c(c_big)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [2047:0] got, input logic [2047:0] exp);
        int w;
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            w = 0;
            for (int i = 31; i >= 0; i--) begin
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            end
            $display("FAIL %s: got %h want %h (64-bit word %0d)", tag,
                     got[w*64 +: 64], exp[w*64 +: 64], w);
        end
    endtask

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Expected latency for the 1024/16 early-exit instance.
    function automatic int big_lat(input logic [1023:0] bv);
        int k;
        k = -1;
        for (int i = 0; i < 64; i++) begin
            if (bv[i*16 +: 16] != 16'h0) k = i;
        end
        return (k < 0) ? 1 : k + 2;
    endfunction

    // Scoreboard side of the big instance.
    always @(negedge clk) begin
        if (done_big) begin
            chk_val("big_sb_nonempty", 2048'(sb_q.size() != 0), 2048'(1));
            if (sb_q.size() != 0) chk_val("big_c", c_big, sb_q.pop_front());
            if (b2b && last_done >= 0) chk_val("big_period", 2048'(cyc - last_done), 2048'(66));
            last_done = cyc;
        end
    end

    // Small-instance run; called and returns at a negedge.
    task automatic small_run(input int k, input logic [31:0] av, input logic [31:0] bv, input int lat);
        logic [63:0] exp_c;
        logic        bz, dn;
        logic [63:0] cc;
        string       nm;
        exp_c = 64'(av) * 64'(bv);
        nm = (k == 0) ? "ne" : (k == 1) ? "ee" : "pad";
        case (k)
            0: begin a_ne = av; b_ne = bv; start_ne = 1'b1; end
            1: begin a_ee = av; b_ee = bv; start_ee = 1'b1; end
            default: begin a_pad = av[16:0]; b_pad = bv[19:0]; start_pad = 1'b1; end
        endcase
        @(posedge clk);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            start_ne = 1'b0; start_ee = 1'b0; start_pad = 1'b0;
            case (k)
                0: begin bz = busy_ne; dn = done_ne; end
                1: begin bz = busy_ee; dn = done_ee; end
                default: begin bz = busy_pad; dn = done_pad; end
            endcase
            chk_val({nm, "_busy"}, 2048'(bz), 2048'(i < lat));
            chk_val({nm, "_done"}, 2048'(dn), 2048'(i == lat));
        end
        case (k)
            0: cc = c_ne;
            1: cc = c_ee;
            default: cc = {27'b0, c_pad};
        endcase
        chk_val({nm, "_c"}, 2048'(cc), 2048'(exp_c));
        @(negedge clk);
        case (k)
            0: dn = done_ne;
            1: dn = done_ee;
            default: dn = done_pad;
        endcase
        chk_val({nm, "_done_drop"}, 2048'(dn), 2048'(0));
    endtask

    // Big-instance operation. mode 0: start dropped after acceptance,
    // mode 1: start held high (back-to-back), mode 2: start dropped and
    // pulsed again while busy. Entered and left at a negedge.
    task automatic big_op(input logic [1023:0] av, input logic [1023:0] bv, input int mode);
        int lat;
        lat = big_lat(bv);
        chk_val("big_idle_before", 2048'(busy_big), 2048'(0));
        a_big = av;
        b_big = bv;
        start_big = 1'b1;
        sb_q.push_back(2048'(av) * 2048'(bv));
        @(posedge clk);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            a_big = rand1024();
            b_big = rand1024();
            if (mode == 0) start_big = 1'b0;
            if (mode == 2) start_big = (i == 2);
            chk_val("big_busy", 2048'(busy_big), 2048'(i < lat));
            chk_val("big_done", 2048'(done_big), 2048'(i == lat));
            if (i < lat) chk_val("big_hold", c_big, prev_c);
        end
        prev_c = 2048'(av) * 2048'(bv);
    endtask

    task automatic big_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_val("big_idle_done", 2048'(done_big), 2048'(0));
            chk_val("big_idle_busy", 2048'(busy_big), 2048'(0));
            chk_val("big_idle_hold", c_big, prev_c);
        end
    endtask

    initial begin
        logic [1023:0] ra, rb;
        rst = 1'b1;
        start_ne = 1'b0; start_ee = 1'b0; start_pad = 1'b0; start_big = 1'b0;
        a_ne = '0; b_ne = '0; a_ee = '0; b_ee = '0; a_pad = '0; b_pad = '0;
        a_big = '0; b_big = '0;
        repeat (3) @(negedge clk);
        chk_val("rst_busy_ne", 2048'(busy_ne), 2048'(0));
        chk_val("rst_done_ee", 2048'(done_ee), 2048'(0));
        chk_val("rst_c_pad", 2048'(c_pad), 2048'(0));
        chk_val("rst_busy_big", 2048'(busy_big), 2048'(0));
        chk_val("rst_done_big", 2048'(done_big), 2048'(0));
        chk_val("rst_c_big", c_big, 2048'(0));
        rst = 1'b0;
        @(negedge clk);

        small_run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        small_run(0, 32'h1234_5678, 32'h0000_00AB, 5);
        small_run(1, 32'h1234_5678, 32'h0000_00AB, 2);
        small_run(1, 32'h1234_5678, 32'h0000_0000, 1);
        small_run(1, 32'hDEAD_BEEF, 32'h00AB_0000, 4);
        small_run(1, 32'hFFFF_FFFF, 32'h0100_0000, 5);
        small_run(2, 32'h0001_FFFF, 32'h000F_FFFF, 4);
        small_run(2, 32'h0001_ABCD, 32'h0000_0003, 4);

        // start pulsed while busy must be ignored
        rb = rand1024();
        rb[1023] = 1'b1;
        big_op(rand1024(), rb, 2);
        big_idle(5);

        // early-exit cases on the wide instance
        big_op(rand1024(), '0, 0);
        big_idle(2);
        rb = '0;
        rb[5*16 +: 16] = 16'h8001;
        big_op(rand1024(), rb, 0);
        big_idle(2);

        // reset during RUN discards the operation
        ra = rand1024();
        rb = rand1024();
        rb[1023] = 1'b1;
        a_big = ra;
        b_big = rb;
        start_big = 1'b1;
        sb_q.push_back(2048'(ra) * 2048'(rb));
        @(posedge clk);
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            start_big = 1'b0;
        end
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk_val("midrst_busy", 2048'(busy_big), 2048'(0));
        chk_val("midrst_done", 2048'(done_big), 2048'(0));
        chk_val("midrst_c", c_big, 2048'(0));
        rst = 1'b0;
        prev_c = '0;
        big_idle(70);

        // fresh start after reset
        rb = rand1024();
        rb[1023] = 1'b1;
        big_op(rand1024(), rb, 0);
        big_idle(3);

        // 200 back-to-back operations with start held high
        b2b = 1'b1;
        last_done = -1;
        for (int n = 0; n < 200; n++) begin
            rb = rand1024();
            rb[1023] = 1'b1;
            big_op(rand1024(), rb, 1);
        end
        start_big = 1'b0;
        big_idle(5);
        b2b = 1'b0;
        chk_val("big_sb_drained", 2048'(sb_q.size()), 2048'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
